inst_decode_stage: RTL and testbench
====================================

INST_DECODE_STAGE -- requirements
Module: inst_decode_stage

Interface
REQ-001 The block SHALL have these parameters:
- XLEN, default 32: datapath width, 32 or 64. It sets the pc/imm width and enables the RV64 opcodes.
- SKID, default 1: 1 adds a one-entry skid buffer with registered in_ready; 0 gives no skid buffer and a combinational in_ready.

REQ-002 The block SHALL have these ports:
- clk, in, 1: single clock; all state updates on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- flush, in, 1: synchronous discard of all held entries.
- in_valid, in, 1: upstream instruction valid.
- in_ready, out, 1: stage can accept.
- in_inst, in, 32: raw instruction word.
- in_pc, in, XLEN: instruction address.
- out_valid, out, 1: decoded entry valid.
- out_ready, in, 1: downstream accepts.
- out_pc, out, XLEN: pc of the decoded entry.
- out_rd / out_rs1 / out_rs2, out, 5 each: bits [11:7] / [19:15] / [24:20].
- out_opcode, out, 7: bits [6:0].
- out_funct3, out, 3: bits [14:12].
- out_funct7, out, 7: bits [31:25].
- out_imm, out, XLEN: sign-extended immediate.
- out_fmt, out, 3: format code R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
- out_illegal, out, 1: opcode not supported.

Function
REQ-003 Decode SHALL be computed from in_inst and registered with 1-cycle latency: an entry accepted at edge N is presented with out_valid=1 after edge N.
REQ-004 Transfers SHALL occur on in_valid&&in_ready (input side) and out_valid&&out_ready (output side); out_* payload SHALL stay stable while out_valid=1 and out_ready=0.
REQ-005 Format map: 0110011 -> R; 0010011, 0000011, 1100111, 1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J.
REQ-006 When XLEN=64, 0111011 SHALL additionally decode as R and 0011011 as I; when XLEN=32 both SHALL decode as illegal.
REQ-007 Any other opcode, including any opcode with [1:0]!=2'b11, SHALL give out_fmt=7, out_illegal=1, out_imm=0; field outputs still carry the raw bit slices.
REQ-008 Immediates SHALL follow the RV base encodings, each sign-extended from inst[31] to XLEN:
- I = inst[31:20]
- S = {inst[31:25], inst[11:7]}
- B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}
- U = {inst[31:12], 12'b0}
- J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- R: out_imm SHALL be 0.
REQ-009 With SKID=1, the storage SHALL be an output register plus one skid entry, and in_ready SHALL equal !skid_valid (registered).
REQ-010 With SKID=1, at each edge: if output empty or out_ready=1, the output register SHALL load the skid entry if one is held, otherwise the accepted input; else an accepted input SHALL go to the skid entry.
REQ-011 Simultaneous output drain and skid refill with a new input accept SHALL move skid to output and new input to skid, with no loss and in-order delivery.
REQ-012 With SKID=0, in_ready SHALL equal !out_valid || out_ready (combinational), and there SHALL be no skid entry.
REQ-013 flush=1 at an edge SHALL clear out_valid and skid_valid; an input presented in that cycle SHALL be dropped; in_ready SHALL be 1 after that edge.
REQ-014 flush SHALL take priority over all accept and drain activity in the same cycle.

Reset
REQ-015 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- out_valid=0 and skid empty;
- all out_* payload to 0;
- in_ready=1 (SKID=1).
REQ-016 Reset asserted mid-stream SHALL discard all held entries; after rst_n deasserts, the first accepted input SHALL be the first entry output.

Verification
REQ-017 in_inst=0xFFF00093 (addi x1,x0,-1), in_pc=0x100 -> next cycle:
- out_valid=1, out_rd=1, out_rs1=0;
- out_fmt=1, out_imm=0xFFFFFFFF, out_pc=0x100.
REQ-018 in_inst=0x0020A423 (sw x2,8(x1)) -> out_fmt=2, out_rs1=1, out_rs2=2, out_funct3=2, out_imm=8.
REQ-019 Jump and illegal decode:
- in_inst=0xFFDFF06F (jal x0,-4) -> out_fmt=5, out_imm=0xFFFFFFFC.
- in_inst=0x00000000 -> out_illegal=1, out_fmt=7, out_imm=0.
REQ-020 Backpressure, SKID=1:
- out_ready=0 while pushing A, B, C -> A held on output, B in skid, in_ready=0, C held upstream.
- Then out_ready=1 -> A, B, C delivered in order on consecutive cycles.
REQ-021 Flush with both entries full -> after the edge, out_valid=0 and in_ready=1; the next input is delivered normally.
REQ-022 XLEN=64, in_inst=0x0000009B (addiw x1,x0,0) -> out_fmt=1, out_illegal=0; the same word at XLEN=32 -> out_illegal=1.

Source files
------------

// File: rtl/inst_decode_stage.sv
// RV instruction decode stage: combinational field/immediate decode of the incoming
// word, registered into an output slot with an optional one-entry skid buffer.
module inst_decode_stage #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;
  localparam logic       IS_RV64 = (XLEN == 64);
  localparam int         PW      = 2 * XLEN + 36;

  logic [2:0]      dec_fmt;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic [PW-1:0]   in_pkt;
  logic [PW-1:0]   out_pkt_reg;
  logic            out_valid_reg;
  logic            accept;
  logic            out_load;

  always_comb begin
    dec_fmt = FMT_ILL;
    case (in_inst[6:0])
      7'b0110011:                                     dec_fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_fmt = FMT_I;
      7'b0100011:                                     dec_fmt = FMT_S;
      7'b1100011:                                     dec_fmt = FMT_B;
      7'b0110111, 7'b0010111:                         dec_fmt = FMT_U;
      7'b1101111:                                     dec_fmt = FMT_J;
      7'b0111011:                                     dec_fmt = IS_RV64 ? FMT_R : FMT_ILL;
      7'b0011011:                                     dec_fmt = IS_RV64 ? FMT_I : FMT_ILL;
      default:                                        dec_fmt = FMT_ILL;
    endcase
  end

  // Every immediate is built as a 32-bit signed value first, then widened by inst[31].
  always_comb begin
    dec_imm32 = 32'd0;
    case (dec_fmt)
      FMT_I: dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      FMT_S: dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      FMT_B: dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                          in_inst[11:8], 1'b0};
      FMT_U: dec_imm32 = {in_inst[31:12], 12'd0};
      FMT_J: dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                          in_inst[30:21], 1'b0};
      default: dec_imm32 = 32'd0;
    endcase
  end

  always_comb begin
    dec_imm        = {XLEN{dec_imm32[31]}};
    dec_imm[31:0]  = dec_imm32;
  end

  assign dec_illegal = (dec_fmt == FMT_ILL);

  assign in_pkt = {in_pc, in_inst[11:7], in_inst[19:15], in_inst[24:20], in_inst[6:0],
                   in_inst[14:12], in_inst[31:25], dec_imm, dec_fmt, dec_illegal};

  assign {out_pc, out_rd, out_rs1, out_rs2, out_opcode, out_funct3, out_funct7,
          out_imm, out_fmt, out_illegal} = out_pkt_reg;
  assign out_valid = out_valid_reg;
  assign accept    = in_valid && in_ready;
  assign out_load  = !out_valid_reg || out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic          skid_valid_reg;
      logic [PW-1:0] skid_pkt_reg;

      assign in_ready = !skid_valid_reg;

      // The skid entry is always older than any new input, so it drains first.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_reg  <= 1'b0;
          out_pkt_reg    <= '0;
          skid_valid_reg <= 1'b0;
          skid_pkt_reg   <= '0;
        end else if (flush) begin
          out_valid_reg  <= 1'b0;
          skid_valid_reg <= 1'b0;
        end else if (out_load) begin
          if (skid_valid_reg) begin
            out_pkt_reg    <= skid_pkt_reg;
            out_valid_reg  <= 1'b1;
            skid_valid_reg <= accept;
            if (accept) skid_pkt_reg <= in_pkt;
          end else begin
            out_valid_reg <= accept;
            if (accept) out_pkt_reg <= in_pkt;
          end
        end else if (accept) begin
          skid_pkt_reg   <= in_pkt;
          skid_valid_reg <= 1'b1;
        end
      end
    end else begin : g_noskid
      assign in_ready = !out_valid_reg || out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_reg <= 1'b0;
          out_pkt_reg   <= '0;
        end else if (flush) begin
          out_valid_reg <= 1'b0;
        end else if (out_load) begin
          out_valid_reg <= accept;
          if (accept) out_pkt_reg <= in_pkt;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench: RV32 skid-buffered stage plus an RV64 stage without skid on shared stimulus.
module tb_inst_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic [63:0] in_pc64;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3, out_fmt;

  logic        r64, v64, ill64;
  logic [63:0] pc64, imm64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [6:0]  op64, f7_64;
  logic [2:0]  f3_64, fmt64;

  int errors = 0;
  int checks = 0;

  assign in_pc64 = {32'd0, in_pc};

  always #5 clk = ~clk;

  inst_decode_stage #(.XLEN(32), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  inst_decode_stage #(.XLEN(64), .SKID(0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_inst(in_inst), .in_pc(in_pc64), .out_valid(v64), .out_ready(out_ready),
    .out_pc(pc64), .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
    .out_opcode(op64), .out_funct3(f3_64), .out_funct7(f7_64),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    $display("cycle: in_ready=%0b out_valid=%0b pc=%h fmt=%0d imm=%h", in_ready, out_valid,
             out_pc, out_fmt, out_imm);
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'd0; in_pc = 32'd0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", in_ready); end
    checks++; if (out_pc !== 32'd0 || out_imm !== 32'd0 || out_fmt !== 3'd0) begin errors++;
      $display("FAIL rst_payload: got pc=%h imm=%h fmt=%0d expected all 0", out_pc, out_imm, out_fmt); end
    #10 rst_n = 1'b1;
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    push(32'hFFF00093, 32'h100);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b expected 1", out_valid); end
    checks++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0) begin errors++;
      $display("FAIL addi_regs: got rd=%0d rs1=%0d expected rd=1 rs1=0", out_rd, out_rs1); end
    checks++; if (out_fmt !== 3'd1) begin errors++; $display("FAIL addi_fmt: got %0d expected 1", out_fmt); end
    checks++; if (out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm: got %h expected ffffffff", out_imm); end
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL addi_pc: got %h expected 100", out_pc); end
    checks++; if (imm64 !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL addi_imm64: got %h expected all ones", imm64); end
  endtask

  task automatic test_store();
    push(32'h0020A423, 32'h104);
    checks++; if (out_fmt !== 3'd2) begin errors++; $display("FAIL sw_fmt: got %0d expected 2", out_fmt); end
    checks++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin errors++;
      $display("FAIL sw_regs: got rs1=%0d rs2=%0d expected 1 2", out_rs1, out_rs2); end
    checks++; if (out_funct3 !== 3'd2) begin errors++; $display("FAIL sw_funct3: got %0d expected 2", out_funct3); end
    checks++; if (out_imm !== 32'd8) begin errors++; $display("FAIL sw_imm: got %h expected 8", out_imm); end
  endtask

  task automatic test_formats();
    push(32'hFFDFF06F, 32'h108);
    checks++; if (out_fmt !== 3'd5 || out_imm !== 32'hFFFFFFFC) begin errors++;
      $display("FAIL jal: got fmt=%0d imm=%h expected 5 fffffffc", out_fmt, out_imm); end
    push(32'hFE208CE3, 32'h10C);
    checks++; if (out_fmt !== 3'd3 || out_imm !== 32'hFFFFFFF8) begin errors++;
      $display("FAIL beq: got fmt=%0d imm=%h expected 3 fffffff8", out_fmt, out_imm); end
    push(32'h123452B7, 32'h110);
    checks++; if (out_fmt !== 3'd4 || out_imm !== 32'h12345000 || out_rd !== 5'd5) begin errors++;
      $display("FAIL lui: got fmt=%0d imm=%h rd=%0d expected 4 12345000 5", out_fmt, out_imm, out_rd); end
    push(32'h402081B3, 32'h114);
    checks++; if (out_fmt !== 3'd0 || out_imm !== 32'd0 || out_funct7 !== 7'h20 || out_rd !== 5'd3) begin errors++;
      $display("FAIL sub: got fmt=%0d imm=%h f7=%h rd=%0d expected 0 0 20 3", out_fmt, out_imm, out_funct7, out_rd); end
    push(32'h00000000, 32'h118);
    checks++; if (out_illegal !== 1'b1 || out_fmt !== 3'd7 || out_imm !== 32'd0) begin errors++;
      $display("FAIL zero: got ill=%b fmt=%0d imm=%h expected 1 7 0", out_illegal, out_fmt, out_imm); end
    push(32'hFFF00092, 32'h11C);
    checks++; if (out_illegal !== 1'b1 || out_imm !== 32'd0 || out_rd !== 5'd1 || out_opcode !== 7'h12) begin errors++;
      $display("FAIL low_bits: got ill=%b imm=%h rd=%0d op=%h expected 1 0 1 12", out_illegal, out_imm, out_rd, out_opcode); end
  endtask

  task automatic test_rv64();
    push(32'h0000009B, 32'h120);
    checks++; if (fmt64 !== 3'd1 || ill64 !== 1'b0) begin errors++;
      $display("FAIL addiw64: got fmt=%0d ill=%b expected 1 0", fmt64, ill64); end
    checks++; if (out_illegal !== 1'b1 || out_fmt !== 3'd7) begin errors++;
      $display("FAIL addiw32: got ill=%b fmt=%0d expected 1 7", out_illegal, out_fmt); end
    push(32'h002080BB, 32'h124);
    checks++; if (fmt64 !== 3'd0 || ill64 !== 1'b0 || out_illegal !== 1'b1) begin errors++;
      $display("FAIL addw: got fmt64=%0d ill64=%b ill32=%b expected 0 0 1", fmt64, ill64, out_illegal); end
    checks++; if (pc64 !== 64'h124) begin errors++; $display("FAIL pc64: got %h expected 124", pc64); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    push(32'hFFF00093, 32'h200);
    checks++; if (out_pc !== 32'h200 || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_a: got pc=%h ready=%b expected 200 1", out_pc, in_ready); end
    checks++; if (r64 !== 1'b0) begin errors++; $display("FAIL noskid_ready: got %b expected 0", r64); end
    push(32'h0020A423, 32'h204);
    checks++; if (out_pc !== 32'h200 || in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_b: got pc=%h ready=%b expected 200 0", out_pc, in_ready); end
    push(32'h123452B7, 32'h208);
    checks++; if (out_pc !== 32'h200 || out_rd !== 5'd1 || out_fmt !== 3'd1 || in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_hold: got pc=%h rd=%0d fmt=%0d ready=%b expected 200 1 1 0", out_pc, out_rd, out_fmt, in_ready); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h204 || out_fmt !== 3'd2 || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_drain_b: got v=%b pc=%h fmt=%0d ready=%b expected 1 204 2 1", out_valid, out_pc, out_fmt, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h208 || out_fmt !== 3'd4) begin errors++;
      $display("FAIL bp_drain_c: got v=%b pc=%h fmt=%0d expected 1 208 4", out_valid, out_pc, out_fmt); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push(32'hFFF00093, 32'h300);
    push(32'h0020A423, 32'h304);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_full: got ready=%b expected 0", in_ready); end
    flush = 1'b1;
    push(32'h123452B7, 32'h308);
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || v64 !== 1'b0) begin errors++;
      $display("FAIL fl_clear: got v=%b ready=%b v64=%b expected 0 1 0", out_valid, in_ready, v64); end
    out_ready = 1'b1;
    push(32'hFFDFF06F, 32'h30C);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h30C || out_fmt !== 3'd5) begin errors++;
      $display("FAIL fl_next: got v=%b pc=%h fmt=%0d expected 1 30c 5", out_valid, out_pc, out_fmt); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_drop: got v=%b expected 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    push(32'hFFF00093, 32'h400);
    push(32'h0020A423, 32'h404);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'd0 || out_imm !== 32'd0) begin errors++;
      $display("FAIL ar_clear: got v=%b ready=%b pc=%h imm=%h expected 0 1 0 0", out_valid, in_ready, out_pc, out_imm); end
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    push(32'h123452B7, 32'h500);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h500) begin errors++;
      $display("FAIL ar_first: got v=%b pc=%h expected 1 500", out_valid, out_pc); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_stale: got v=%b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_store();
    test_formats();
    test_rv64();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
